axi4s_demux_tid: RTL and testbench

// - AXI4-S packet demultiplexer: routes one input stream to 1 of nr_of_streams_p output streams, selected by tid.
// - Counterpart of the round-robin AXI4-S mux: the mux output (tdata/tlast/tid) connects straight to this block's input.
// - Routing is per packet: tid is sampled on the first beat and held until the tlast beat. Outputs sit behind one register stage.

---
 rtl/axi4s_demux_tid.sv | 187 ++++++++++++++++++
 tb/tb_axi4s_demux_tid.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/axi4s_demux_tid.sv
`default_nettype none
// ============================================================================
// Module      : axi4s_demux_tid
// Description : AXI4-Stream packet demultiplexer. One input stream is routed
//               to one of nr_of_streams_p outputs, selected by tid sampled on
//               the first beat of each packet. Packets whose tid is outside
//               the output range are consumed and counted as drops. Outputs
//               sit behind a single register stage.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4s_demux_tid #(
    parameter int nr_of_streams_p = 2,
    parameter int tdata_width_p   = 1,
    parameter int tid_bit_width_p = $clog2(nr_of_streams_p)
) (
    input  logic                                                clk,
    input  logic                                                rst,
    output logic                                                axi4s_i_tready,
    input  logic                                                axi4s_i_tvalid,
    input  logic                                                axi4s_i_tlast,
    input  logic [tid_bit_width_p-1:0]                          axi4s_i_tid,
    input  logic [tdata_width_p*8-1:0]                          axi4s_i_tdata,
    input  logic [nr_of_streams_p-1:0]                          axi4s_o_tready,
    output logic [nr_of_streams_p-1:0]                          axi4s_o_tvalid,
    output logic [nr_of_streams_p-1:0]                          axi4s_o_tlast,
    output logic [nr_of_streams_p-1:0][tdata_width_p*8-1:0]     axi4s_o_tdata,
    output logic                                                drop_pkt,
    output logic [15:0]                                         drop_count
);

    localparam int c_DATA_W = tdata_width_p * 8;

    typedef enum logic [1:0] {
        ST_SOP  = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_state_next;

    // Output beat register and per-packet routing state
    logic                         r_full;
    logic [c_DATA_W-1:0]          r_data;
    logic                         r_last;
    logic [tid_bit_width_p-1:0]   r_sel;
    logic [tid_bit_width_p-1:0]   r_pkt_dest;
    logic                         r_drop_pkt;
    logic [15:0]                  r_drop_count;

    logic                         w_can_load;
    logic                         w_tid_in_range;
    logic                         w_accept;
    logic                         w_tready;
    logic                         w_load;
    logic [tid_bit_width_p-1:0]   w_load_sel;
    logic                         w_set_dest;
    logic                         w_drop_done;

    // The register can take a new beat when empty or when its beat drains this cycle
    assign w_can_load     = !r_full || axi4s_o_tready[r_sel];
    assign w_tid_in_range = int'(axi4s_i_tid) < nr_of_streams_p;
    // Ready is held low during reset so nothing is offered as accepted
    assign axi4s_i_tready = w_tready && !rst;
    assign w_accept       = axi4s_i_tvalid && axi4s_i_tready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_SOP;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, input ready and load decisions
    always_comb begin
        w_state_next = r_state;
        w_tready     = 1'b0;
        w_load       = 1'b0;
        w_load_sel   = r_pkt_dest;
        w_set_dest   = 1'b0;
        w_drop_done  = 1'b0;
        case (r_state)
            ST_SOP: begin
                if (w_tid_in_range) begin
                    w_tready = w_can_load;
                    if (w_accept) begin
                        w_load     = 1'b1;
                        w_load_sel = axi4s_i_tid;
                        w_set_dest = 1'b1;
                        if (!axi4s_i_tlast) begin
                            w_state_next = ST_FWD;
                        end
                    end
                end else begin
                    // Unroutable packet: swallow it at full rate
                    w_tready = 1'b1;
                    if (w_accept) begin
                        if (axi4s_i_tlast) begin
                            w_drop_done = 1'b1;
                        end else begin
                            w_state_next = ST_DROP;
                        end
                    end
                end
            end
            ST_FWD: begin
                w_tready = w_can_load;
                if (w_accept) begin
                    w_load = 1'b1;
                    if (axi4s_i_tlast) begin
                        w_state_next = ST_SOP;
                    end
                end
            end
            ST_DROP: begin
                w_tready = 1'b1;
                if (w_accept && axi4s_i_tlast) begin
                    w_drop_done  = 1'b1;
                    w_state_next = ST_SOP;
                end
            end
            default: begin
                w_state_next = ST_SOP;
            end
        endcase
    end

    // Output register: load wins over drain so consecutive beats flow without bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full     <= 1'b0;
            r_data     <= '0;
            r_last     <= 1'b0;
            r_sel      <= '0;
            r_pkt_dest <= '0;
        end else begin
            if (w_load) begin
                r_full <= 1'b1;
                r_data <= axi4s_i_tdata;
                r_last <= axi4s_i_tlast;
                r_sel  <= w_load_sel;
            end else if (r_full && axi4s_o_tready[r_sel]) begin
                r_full <= 1'b0;
            end
            if (w_set_dest) begin
                r_pkt_dest <= axi4s_i_tid;
            end
        end
    end

    // Drop pulse and saturating drop counter move together
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_pkt   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_drop_pkt <= w_drop_done;
            if (w_drop_done && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    // Only the selected output sees valid and last
    always_comb begin
        axi4s_o_tvalid = '0;
        axi4s_o_tlast  = '0;
        if (r_full) begin
            axi4s_o_tvalid[r_sel] = 1'b1;
            axi4s_o_tlast[r_sel]  = r_last;
        end
    end

    // The registered beat is broadcast on every output data bus
    generate
        for (genvar g = 0; g < nr_of_streams_p; g++) begin : g_tdata
            assign axi4s_o_tdata[g] = r_data;
        end
    endgenerate

    assign drop_pkt   = r_drop_pkt;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_axi4s_demux_tid.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4s_demux_tid
// Description : Directed, table-driven bench for axi4s_demux_tid with N=3,
//               one-byte data, plus a hand-written mid-packet reset sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4s_demux_tid;

    localparam int c_N = 3;

    logic             clk;
    logic             rst;
    logic             i_tready;
    logic             i_tvalid;
    logic             i_tlast;
    logic [1:0]       i_tid;
    logic [7:0]       i_tdata;
    logic [2:0]       o_tready;
    logic [2:0]       o_tvalid;
    logic [2:0]       o_tlast;
    logic [2:0][7:0]  o_tdata;
    logic             drop_pkt;
    logic [15:0]      drop_count;

    int total;
    int bad;

    axi4s_demux_tid #(
        .nr_of_streams_p (c_N),
        .tdata_width_p   (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .axi4s_i_tready (i_tready),
        .axi4s_i_tvalid (i_tvalid),
        .axi4s_i_tlast  (i_tlast),
        .axi4s_i_tid    (i_tid),
        .axi4s_i_tdata  (i_tdata),
        .axi4s_o_tready (o_tready),
        .axi4s_o_tvalid (o_tvalid),
        .axi4s_o_tlast  (o_tlast),
        .axi4s_o_tdata  (o_tdata),
        .drop_pkt       (drop_pkt),
        .drop_count     (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        l;
        logic [1:0]  tid;
        logic [7:0]  d;
        logic [2:0]  ordy;
        logic        e_rdy;
        logic [2:0]  e_ov;
        logic [2:0]  e_ol;
        logic [7:0]  e_d;
        logic        e_drop;
        logic [15:0] e_cnt;
    } vec_t;

    localparam int c_NV = 36;
    vec_t vecs [c_NV];

    function automatic vec_t mk(input logic v, input logic l, input logic [1:0] tid,
                                input logic [7:0] d, input logic [2:0] ordy,
                                input logic e_rdy, input logic [2:0] e_ov,
                                input logic [2:0] e_ol, input logic [7:0] e_d,
                                input logic e_drop, input logic [15:0] e_cnt);
        vec_t r;
        r.v = v; r.l = l; r.tid = tid; r.d = d; r.ordy = ordy;
        r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_ol = e_ol; r.e_d = e_d;
        r.e_drop = e_drop; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare all registered outputs against the expected beat
    task automatic check_out(input string tag, input logic [2:0] e_ov, input logic [2:0] e_ol,
                             input logic [7:0] e_d, input logic e_drop, input logic [15:0] e_cnt);
        check({tag, ".o_tvalid"}, 32'(o_tvalid), 32'(e_ov));
        check({tag, ".o_tlast"}, 32'(o_tlast & e_ov), 32'(e_ol & e_ov));
        if (e_ov != 3'b000) begin
            for (int p = 0; p < c_N; p++) begin
                check($sformatf("%s.o_tdata[%0d]", tag, p), 32'(o_tdata[p]), 32'(e_d));
            end
        end
        check({tag, ".drop_pkt"}, 32'(drop_pkt), 32'(e_drop));
        check({tag, ".drop_count"}, 32'(drop_count), 32'(e_cnt));
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //              v  l  tid d      ordy    rdy ov      ol      e_d    drp cnt
        // single-beat packet to output 2
        vecs[0]  = mk(1, 1, 2, 8'hA5, 3'b111, 1, 3'b000, 3'b000, 8'h00, 0, 0);
        vecs[1]  = mk(0, 0, 0, 8'h00, 3'b111, 1, 3'b100, 3'b100, 8'hA5, 0, 0);
        vecs[2]  = mk(0, 0, 0, 8'h00, 3'b111, 1, 3'b000, 3'b000, 8'h00, 0, 0);
        // 4-beat packet, tid=1 then tid changes to 0 mid-packet
        vecs[3]  = mk(1, 0, 1, 8'h10, 3'b111, 1, 3'b000, 3'b000, 8'h00, 0, 0);
        vecs[4]  = mk(1, 0, 0, 8'h11, 3'b111, 1, 3'b010, 3'b000, 8'h10, 0, 0);
        vecs[5]  = mk(1, 0, 0, 8'h12, 3'b111, 1, 3'b010, 3'b000, 8'h11, 0, 0);
        vecs[6]  = mk(1, 1, 0, 8'h13, 3'b111, 1, 3'b010, 3'b000, 8'h12, 0, 0);
        vecs[7]  = mk(0, 0, 0, 8'h00, 3'b111, 1, 3'b010, 3'b010, 8'h13, 0, 0);
        vecs[8]  = mk(0, 0, 0, 8'h00, 3'b111, 1, 3'b000, 3'b000, 8'h00, 0, 0);
        // backpressure on sink 0 for 3 cycles; other sinks ready but ignored
        vecs[9]  = mk(1, 0, 0, 8'h20, 3'b111, 1, 3'b000, 3'b000, 8'h00, 0, 0);
        vecs[10] = mk(1, 0, 0, 8'h21, 3'b110, 0, 3'b001, 3'b000, 8'h20, 0, 0);
        vecs[11] = mk(1, 0, 0, 8'h21, 3'b110, 0, 3'b001, 3'b000, 8'h20, 0, 0);
        vecs[12] = mk(1, 0, 0, 8'h21, 3'b110, 0, 3'b001, 3'b000, 8'h20, 0, 0);
        vecs[13] = mk(1, 0, 0, 8'h21, 3'b111, 1, 3'b001, 3'b000, 8'h20, 0, 0);
        vecs[14] = mk(1, 1, 0, 8'h22, 3'b111, 1, 3'b001, 3'b000, 8'h21, 0, 0);
        vecs[15] = mk(0, 0, 0, 8'h00, 3'b111, 1, 3'b001, 3'b001, 8'h22, 0, 0);
        vecs[16] = mk(0, 0, 0, 8'h00, 3'b111, 1, 3'b000, 3'b000, 8'h00, 0, 0);
        // 3-beat out-of-range packet (later beats carry a valid tid), then tid=0
        vecs[17] = mk(1, 0, 3, 8'h30, 3'b111, 1, 3'b000, 3'b000, 8'h00, 0, 0);
        vecs[18] = mk(1, 0, 0, 8'h31, 3'b111, 1, 3'b000, 3'b000, 8'h00, 0, 0);
        vecs[19] = mk(1, 1, 0, 8'h32, 3'b111, 1, 3'b000, 3'b000, 8'h00, 0, 0);
        vecs[20] = mk(1, 1, 0, 8'h40, 3'b111, 1, 3'b000, 3'b000, 8'h00, 1, 1);
        vecs[21] = mk(0, 0, 0, 8'h00, 3'b111, 1, 3'b001, 3'b001, 8'h40, 0, 1);
        // back-to-back packets to output 0 then output 2
        vecs[22] = mk(1, 0, 0, 8'h50, 3'b111, 1, 3'b000, 3'b000, 8'h00, 0, 1);
        vecs[23] = mk(1, 1, 0, 8'h51, 3'b111, 1, 3'b001, 3'b000, 8'h50, 0, 1);
        vecs[24] = mk(1, 0, 2, 8'h52, 3'b111, 1, 3'b001, 3'b001, 8'h51, 0, 1);
        vecs[25] = mk(1, 1, 2, 8'h53, 3'b111, 1, 3'b100, 3'b000, 8'h52, 0, 1);
        vecs[26] = mk(0, 0, 0, 8'h00, 3'b111, 1, 3'b100, 3'b100, 8'h53, 0, 1);
        vecs[27] = mk(0, 0, 0, 8'h00, 3'b111, 1, 3'b000, 3'b000, 8'h00, 0, 1);
        // single-beat out-of-range packet
        vecs[28] = mk(1, 1, 3, 8'h60, 3'b111, 1, 3'b000, 3'b000, 8'h00, 0, 1);
        vecs[29] = mk(0, 0, 0, 8'h00, 3'b111, 1, 3'b000, 3'b000, 8'h00, 1, 2);
        vecs[30] = mk(0, 0, 0, 8'h00, 3'b111, 1, 3'b000, 3'b000, 8'h00, 0, 2);
        // stalled sink 2 blocks a packet for sink 0 even though sink 0 is ready
        vecs[31] = mk(1, 1, 2, 8'h70, 3'b111, 1, 3'b000, 3'b000, 8'h00, 0, 2);
        vecs[32] = mk(1, 1, 0, 8'h71, 3'b011, 0, 3'b100, 3'b100, 8'h70, 0, 2);
        vecs[33] = mk(1, 1, 0, 8'h71, 3'b111, 1, 3'b100, 3'b100, 8'h70, 0, 2);
        vecs[34] = mk(0, 0, 0, 8'h00, 3'b111, 1, 3'b001, 3'b001, 8'h71, 0, 2);
        vecs[35] = mk(0, 0, 0, 8'h00, 3'b111, 1, 3'b000, 3'b000, 8'h00, 0, 2);

        rst      = 1'b1;
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        i_tid    = 2'd0;
        i_tdata  = 8'h00;
        o_tready = 3'b111;
        repeat (3) @(negedge clk);

        // Reset state
        check("reset.i_tready", 32'(i_tready), 32'd0);
        check_out("reset", 3'b000, 3'b000, 8'h00, 1'b0, 16'd0);

        rst = 1'b0;
        for (int k = 0; k < c_NV; k++) begin
            i_tvalid = vecs[k].v;
            i_tlast  = vecs[k].l;
            i_tid    = vecs[k].tid;
            i_tdata  = vecs[k].d;
            o_tready = vecs[k].ordy;
            #1;
            check($sformatf("v%0d.i_tready", k), 32'(i_tready), 32'(vecs[k].e_rdy));
            check_out($sformatf("v%0d", k), vecs[k].e_ov, vecs[k].e_ol, vecs[k].e_d,
                      vecs[k].e_drop, vecs[k].e_cnt);
            @(negedge clk);
        end

        // Reset in the middle of a tid=1 packet
        i_tvalid = 1'b1; i_tlast = 1'b0; i_tid = 2'd1; i_tdata = 8'h80; o_tready = 3'b000;
        #1;
        check("mrst.beat1.i_tready", 32'(i_tready), 32'd1);
        @(negedge clk);
        i_tvalid = 1'b0;
        #1;
        check_out("mrst.held", 3'b010, 3'b000, 8'h80, 1'b0, 16'd2);
        rst = 1'b1;
        @(negedge clk);
        check("mrst.i_tready", 32'(i_tready), 32'd0);
        check_out("mrst.cleared", 3'b000, 3'b000, 8'h00, 1'b0, 16'd0);
        for (int p = 0; p < c_N; p++) begin
            check($sformatf("mrst.o_tdata[%0d]", p), 32'(o_tdata[p]), 32'd0);
        end
        rst = 1'b0;
        o_tready = 3'b111;
        i_tvalid = 1'b1; i_tlast = 1'b1; i_tid = 2'd2; i_tdata = 8'h90;
        #1;
        check("mrst.sop.i_tready", 32'(i_tready), 32'd1);
        @(negedge clk);
        i_tvalid = 1'b0; i_tlast = 1'b0; i_tid = 2'd0; i_tdata = 8'h00;
        #1;
        check_out("mrst.sop", 3'b100, 3'b100, 8'h90, 1'b0, 16'd0);
        @(negedge clk);
        check_out("mrst.idle", 3'b000, 3'b000, 8'h00, 1'b0, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
